// File: rtl/lif_sched_pkg.sv
// Shared types and constants for the LIF sweep scheduler.
// Optional feature macro used by the top: LIF_REFRACTORY_EN.
package lif_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  localparam logic CFG_SEL_CUR = 1'b0;
  localparam logic CFG_SEL_THR = 1'b1;

  localparam int THR_RST_DEFAULT = 32;

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky integrate-and-fire step: leak, integrate with saturation,
// then threshold compare.
module lif_update_unit #(
  parameter int W          = 6,
  parameter int LEAK_SHIFT = 1
) (
  input  logic [W-1:0] st,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] thr,
  output logic [W-1:0] nxt,
  output logic         spike
);

  logic [W:0] sum;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    sum   = {1'b0, cur} + ({1'b0, st} >> LEAK_SHIFT);
    nxt   = sum[W] ? '1 : sum[W-1:0];
    spike = (nxt >= thr);
  end

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Sweeps one LIF update datapath across N virtual neurons per tick and emits
// spike indices over valid/ready. Define LIF_REFRACTORY_EN for refractory counters.
module lif_sweep_scheduler
  import lif_sched_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int W          = 6,
  parameter int LEAK_SHIFT = 1,
  parameter int THR_RST    = THR_RST_DEFAULT,
  parameter int REFRAC     = 2,
  localparam int AW        = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          tick,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_data,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [AW-1:0] evt_id,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [W-1:0]  mon_state
);

  if (N_NEURONS < 2 || (N_NEURONS & (N_NEURONS - 1)) != 0 || REFRAC < 1) begin : g_bad_params
    $error("N_NEURONS must be a power of two >= 2 and REFRAC >= 1");
  end

  localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

  sched_state_e  state_q, state_d;
  logic [AW-1:0] idx_q;
  logic [W-1:0]  st_q  [N_NEURONS];
  logic [W-1:0]  cur_q [N_NEURONS];
  logic [W-1:0]  thr_q [N_NEURONS];
  logic          overrun_q;

  logic [W-1:0]  upd_nxt;
  logic          upd_spike;
  logic          refr_busy;
  logic          spike_eff;
  logic [W-1:0]  st_wr;

  lif_update_unit #(
    .W         (W),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_update (
    .st   (st_q[idx_q]),
    .cur  (cur_q[idx_q]),
    .thr  (thr_q[idx_q]),
    .nxt  (upd_nxt),
    .spike(upd_spike)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC + 1);
  logic [RW-1:0] refr_q [N_NEURONS];

  assign refr_busy = (refr_q[idx_q] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) refr_q[i] <= '0;
    end else if (ena && state_q == UPDATE) begin
      if (refr_busy)      refr_q[idx_q] <= refr_q[idx_q] - 1'b1;
      else if (upd_spike) refr_q[idx_q] <= RW'(REFRAC);
    end
  end
`else
  assign refr_busy = 1'b0;
`endif

  // A refractory neuron is forced to rest and cannot fire.
  assign spike_eff = upd_spike & ~refr_busy;
  assign st_wr     = (upd_spike | refr_busy) ? '0 : upd_nxt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (tick) state_d = UPDATE;
      UPDATE: begin
        if (spike_eff)              state_d = EMIT;
        else if (idx_q == LAST_IDX) state_d = DONE;
      end
      EMIT:   if (evt_ready) state_d = (idx_q == LAST_IDX) ? DONE : UPDATE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      if ((state_q == UPDATE && !spike_eff) || (state_q == EMIT && evt_ready))
        idx_q <= idx_q + 1'b1;
      if (tick && state_q != IDLE)
        overrun_q <= 1'b1;
    end
  end

  // NOTE: the register arrays are small and need defined values, so they sit on the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) st_q[i] <= '0;
    end else if (ena && state_q == UPDATE) begin
      st_q[idx_q] <= st_wr;
    end
  end

  // The update reads cur/thr before this edge, so a same-cycle write is seen next sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        cur_q[i] <= '0;
        thr_q[i] <= W'(THR_RST);
      end
    end else if (ena && cfg_we) begin
      if (cfg_sel == CFG_SEL_THR) thr_q[cfg_addr] <= cfg_data;
      else                        cur_q[cfg_addr] <= cfg_data;
    end
  end

  assign evt_valid = (state_q == EMIT);
  assign evt_id    = idx_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign overrun   = overrun_q;
  assign mon_state = st_q[cfg_addr];

endmodule
